// File: rtl/flash_cmd_sequencer.sv
// Drives unlock/command bus cycles to a parallel NOR flash from a latched command, polling RY/BY# for program/erase.
// One ack per bus cycle (T_AS+T_WP+T_AH+1 clocks apart); start is a held level, released only in FIN.
module flash_cmd_sequencer #(
  parameter int T_AS   = 1,
  parameter int T_WP   = 2,
  parameter int T_AH   = 1,
  parameter int RB_DLY = 4,
  parameter int TO_W   = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic [3:0]  cmd_code_i,
  input  logic [6:0]  block_addr_i,
  input  logic [15:0] other_addr_i,
  input  logic [15:0] tx_data_i,
  output logic        ack,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] rd_data_o,
  output logic        flash_ce_n,
  output logic        flash_we_n,
  output logic        flash_oe_n,
  output logic [22:0] flash_addr,
  output logic [15:0] flash_dq_o,
  output logic        flash_dq_oe,
  input  logic [15:0] flash_dq_i,
  input  logic        flash_ry_byn_i
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_BDLY, S_BWAIT, S_FIN} state_t;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] dat;
    logic        rd;
    logic        last;
  } cyc_t;

  localparam logic [7:0]      AS_LAST = 8'(T_AS - 1);
  localparam logic [7:0]      WP_LAST = 8'(T_WP - 1);
  localparam logic [7:0]      AH_LAST = 8'(T_AH - 1);
  localparam logic [7:0]      BD_LAST = 8'(RB_DLY - 1);
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [22:0]     A_555   = 23'h000555;
  localparam logic [22:0]     A_2AA   = 23'h0002AA;

  // Bus cycle for a given {code, step}; unlisted codes default to a single write of 0.
  function automatic cyc_t seq_lookup(input logic [3:0] code, input logic [2:0] step,
                                      input logic [6:0] blk, input logic [15:0] oth,
                                      input logic [15:0] tx);
    cyc_t c;
    c.addr = {blk, oth};
    c.dat  = 16'h0000;
    c.rd   = 1'b0;
    c.last = 1'b1;
    case ({code, step})
      {4'd1, 3'd0}: c.rd = 1'b1;
      {4'd2, 3'd0}: c.dat = 16'h00F0;
      {4'd3, 3'd0}, {4'd4, 3'd0}, {4'd5, 3'd0}, {4'd4, 3'd3}, {4'd5, 3'd3}: begin
        c.addr = A_555; c.dat = 16'h00AA; c.last = 1'b0;
      end
      {4'd3, 3'd1}, {4'd4, 3'd1}, {4'd5, 3'd1}, {4'd4, 3'd4}, {4'd5, 3'd4}: begin
        c.addr = A_2AA; c.dat = 16'h0055; c.last = 1'b0;
      end
      {4'd3, 3'd2}: begin c.addr = A_555; c.dat = 16'h00A0; c.last = 1'b0; end
      {4'd3, 3'd3}: c.dat = tx;
      {4'd4, 3'd2}, {4'd5, 3'd2}: begin c.addr = A_555; c.dat = 16'h0080; c.last = 1'b0; end
      {4'd4, 3'd5}: begin c.addr = A_555; c.dat = 16'h0010; end
      {4'd5, 3'd5}: begin c.addr = {blk, 16'h0000}; c.dat = 16'h0030; end
      {4'd6, 3'd0}: c.dat = 16'h00B0;
      {4'd7, 3'd0}: c.dat = 16'h0030;
      default: ;
    endcase
    return c;
  endfunction

  state_t          state;
  logic [2:0]      step_q;
  logic [7:0]      tmr;
  logic            gap;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      code_q;
  logic [6:0]      blk_q;
  logic [15:0]     oth_q;
  logic [15:0]     tx_q;
  cyc_t            cyc;
  logic            wait_rb;

  // In IDLE the first cycle is decoded straight from the inputs so SETUP starts on the capture edge.
  always_comb begin
    if (state == S_IDLE) cyc = seq_lookup(cmd_code_i, 3'd0, block_addr_i, other_addr_i, tx_data_i);
    else                 cyc = seq_lookup(code_q, step_q, blk_q, oth_q, tx_q);
  end

  assign wait_rb = (code_q == 4'd3) || (code_q == 4'd4) || (code_q == 4'd5);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      step_q      <= 3'd0;
      tmr         <= 8'd0;
      gap         <= 1'b0;
      to_cnt      <= '0;
      code_q      <= 4'd0;
      blk_q       <= 7'd0;
      oth_q       <= 16'd0;
      tx_q        <= 16'd0;
      flash_ce_n  <= 1'b1;
      flash_we_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
      flash_dq_oe <= 1'b0;
      flash_addr  <= 23'd0;
      flash_dq_o  <= 16'd0;
      rd_data_o   <= 16'd0;
      ack         <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      ack    <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          code_q <= cmd_code_i;
          blk_q  <= block_addr_i;
          oth_q  <= other_addr_i;
          tx_q   <= tx_data_i;
          step_q <= 3'd0;
          tmr    <= 8'd0;
          gap    <= 1'b0;
          busy_o <= 1'b1;
          if (cmd_code_i == 4'd0 || cmd_code_i[3]) begin
            err_o <= 1'b1;
            state <= S_FIN;
          end else begin
            flash_ce_n  <= 1'b0;
            flash_addr  <= cyc.addr;
            flash_dq_o  <= cyc.dat;
            flash_dq_oe <= ~cyc.rd;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          // gap is the ack clock between cycles: CE# stays high, then the next cycle is driven.
          if (gap) begin
            gap         <= 1'b0;
            tmr         <= 8'd0;
            flash_ce_n  <= 1'b0;
            flash_addr  <= cyc.addr;
            flash_dq_o  <= cyc.dat;
            flash_dq_oe <= ~cyc.rd;
          end else if (tmr == AS_LAST) begin
            tmr        <= 8'd0;
            flash_we_n <= cyc.rd;
            flash_oe_n <= ~cyc.rd;
            state      <= S_PULSE;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_PULSE: begin
          if (tmr == WP_LAST) begin
            if (cyc.rd) rd_data_o <= flash_dq_i;
            tmr        <= 8'd0;
            flash_we_n <= 1'b1;
            flash_oe_n <= 1'b1;
            state      <= S_HOLD;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_HOLD: begin
          if (tmr == AH_LAST) begin
            tmr         <= 8'd0;
            flash_ce_n  <= 1'b1;
            flash_dq_oe <= 1'b0;
            ack         <= 1'b1;
            if (!cyc.last) begin
              step_q <= step_q + 3'd1;
              gap    <= 1'b1;
              state  <= S_SETUP;
            end else if (wait_rb) begin
              state <= S_BDLY;
            end else begin
              done_o <= 1'b1;
              state  <= S_FIN;
            end
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_BDLY: begin
          if (tmr == BD_LAST) begin
            to_cnt <= '0;
            state  <= S_BWAIT;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_BWAIT: begin
          if (flash_ry_byn_i) begin
            done_o <= 1'b1;
            state  <= S_FIN;
          end else if (to_cnt == TO_LAST) begin
            err_o <= 1'b1;
            state <= S_FIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_FIN: if (!start) begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer: reset, RESET/READ/PROGRAM/BLK_ER, illegal code, mid-cycle reset.
module tb_flash_cmd_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cmd_code_i = 4'd0;
  logic [6:0]  block_addr_i = 7'd0;
  logic [15:0] other_addr_i = 16'd0;
  logic [15:0] tx_data_i = 16'd0;
  logic [15:0] flash_dq_i = 16'd0;
  logic        flash_ry_byn_i = 1'b1;
  logic        ack, busy_o, done_o, err_o;
  logic [15:0] rd_data_o;
  logic        flash_ce_n, flash_we_n, flash_oe_n, flash_dq_oe;
  logic [22:0] flash_addr;
  logic [15:0] flash_dq_o;

  int checks = 0;
  int errors = 0;

  int          acks, wr_cnt, err_cnt, done_cnt, oe_cnt, ce_cnt, bad_oe;
  int          err_cyc, done_cyc, last_ack, min_gap, ry_cyc;
  logic        prev_we;
  logic [22:0] wr_addr [8];
  logic [15:0] wr_dat  [8];
  logic [22:0] rd_addr;
  logic [7:0]  ce_exp, we_exp, ack_exp;

  always #5 clk_i = ~clk_i;

  flash_cmd_sequencer #(.T_AS(1), .T_WP(2), .T_AH(1), .RB_DLY(4), .TO_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start(start), .cmd_code_i(cmd_code_i),
    .block_addr_i(block_addr_i), .other_addr_i(other_addr_i), .tx_data_i(tx_data_i),
    .ack(ack), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_data_o(rd_data_o),
    .flash_ce_n(flash_ce_n), .flash_we_n(flash_we_n), .flash_oe_n(flash_oe_n),
    .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
    .flash_dq_i(flash_dq_i), .flash_ry_byn_i(flash_ry_byn_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    acks = 0; wr_cnt = 0; err_cnt = 0; done_cnt = 0; oe_cnt = 0; ce_cnt = 0; bad_oe = 0;
    err_cyc = -1; done_cyc = -1; last_ack = -1000; min_gap = 1000; ry_cyc = -1;
    prev_we = 1'b1; rd_addr = 23'h7FFFFF;
  endtask

  task automatic sample(input int c);
    if (ack) begin
      if (c - last_ack < min_gap) min_gap = c - last_ack;
      last_ack = c;
      acks++;
    end
    if (!flash_we_n && prev_we && wr_cnt < 8) begin
      wr_addr[wr_cnt] = flash_addr;
      wr_dat[wr_cnt]  = flash_dq_o;
      wr_cnt++;
    end
    if (!flash_we_n && !flash_dq_oe) bad_oe++;
    prev_we = flash_we_n;
    if (!flash_oe_n) begin oe_cnt++; rd_addr = flash_addr; end
    if (!flash_ce_n) ce_cnt++;
    if (err_o)  begin err_cnt++;  err_cyc  = c; end
    if (done_o) begin done_cnt++; done_cyc = c; end
  endtask

  initial begin
    // Reset values
    #1 rst_i = 1'b0;
    #2;
    chk("rst_ce_n", flash_ce_n, 1);
    chk("rst_we_n", flash_we_n, 1);
    chk("rst_oe_n", flash_oe_n, 1);
    chk("rst_dq_oe", flash_dq_oe, 0);
    chk("rst_addr", flash_addr, 0);
    chk("rst_dq", flash_dq_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_flags", {ack, busy_o, done_o, err_o}, 0);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // RESET command: start raised in clock 0, waveform checked clock by clock
    ce_exp  = 8'b1110_0001;
    we_exp  = 8'b1111_0011;
    ack_exp = 8'b0010_0000;
    cmd_code_i = 4'd2; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("reset_ce_n_c%0d", c), flash_ce_n, ce_exp[c]);
      chk($sformatf("reset_we_n_c%0d", c), flash_we_n, we_exp[c]);
      chk($sformatf("reset_ack_c%0d", c), ack, ack_exp[c]);
      chk($sformatf("reset_done_c%0d", c), done_o, ack_exp[c]);
      if (c == 1) begin
        chk("reset_dq", flash_dq_o, 16'h00F0);
        chk("reset_dq_oe", flash_dq_oe, 1);
      end
    end
    chk("reset_busy_held", busy_o, 1);
    start = 1'b0;
    tick();
    chk("reset_idle", busy_o, 0);

    // READ command
    clear_stats();
    cmd_code_i = 4'd1; block_addr_i = 7'h01; other_addr_i = 16'h0010; flash_dq_i = 16'hBEEF;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin tick(); sample(c); end
    cmd_code_i = 4'd2; block_addr_i = 7'h7F; other_addr_i = 16'hFFFF;
    chk("read_addr", rd_addr, 23'h010010);
    chk("read_oe_clocks", oe_cnt, 2);
    chk("read_rd_data", rd_data_o, 16'hBEEF);
    chk("read_acks", acks, 1);
    chk("read_writes", wr_cnt, 0);
    chk("read_done", done_cnt, 1);
    start = 1'b0;
    tick();
    chk("read_idle", busy_o, 0);

    // PROGRAM: RY/BY# low until 50 clocks after the last ack
    clear_stats();
    cmd_code_i = 4'd3; block_addr_i = 7'h12; other_addr_i = 16'h3456; tx_data_i = 16'h1234;
    flash_ry_byn_i = 1'b0; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      sample(c);
      if (c == 2) begin tx_data_i = 16'hDEAD; other_addr_i = 16'h0000; end
      if (acks == 4 && ry_cyc < 0 && c == last_ack + 50) begin
        flash_ry_byn_i = 1'b1;
        ry_cyc = c;
      end
    end
    chk("prog_acks", acks, 4);
    chk("prog_ack_gap", min_gap, 5);
    chk("prog_writes", wr_cnt, 4);
    chk("prog_dat0", wr_dat[0], 16'h00AA);
    chk("prog_dat1", wr_dat[1], 16'h0055);
    chk("prog_dat2", wr_dat[2], 16'h00A0);
    chk("prog_dat3", wr_dat[3], 16'h1234);
    chk("prog_addr0", wr_addr[0], 23'h000555);
    chk("prog_addr1", wr_addr[1], 23'h0002AA);
    chk("prog_addr3", wr_addr[3], 23'h123456);
    chk("prog_dq_oe", bad_oe, 0);
    chk("prog_done_cnt", done_cnt, 1);
    chk("prog_done_after_ry", done_cyc, ry_cyc + 1);
    chk("prog_err", err_cnt, 0);
    start = 1'b0;
    tick();
    chk("prog_idle", busy_o, 0);

    // BLK_ER with RY/BY# stuck low: 63-clock timeout after a 4-clock delay
    clear_stats();
    cmd_code_i = 4'd5; block_addr_i = 7'h05; other_addr_i = 16'hFFFF;
    flash_ry_byn_i = 1'b0; start = 1'b1;
    for (int c = 1; c <= 120; c++) begin tick(); sample(c); end
    chk("ber_acks", acks, 6);
    chk("ber_writes", wr_cnt, 6);
    chk("ber_dat2", wr_dat[2], 16'h0080);
    chk("ber_addr4", wr_addr[4], 23'h0002AA);
    chk("ber_addr5", wr_addr[5], 23'h050000);
    chk("ber_dat5", wr_dat[5], 16'h0030);
    chk("ber_err_cnt", err_cnt, 1);
    chk("ber_err_delay", err_cyc - last_ack, 67);
    chk("ber_done", done_cnt, 0);
    start = 1'b0; flash_ry_byn_i = 1'b1;
    tick();
    chk("ber_idle", busy_o, 0);

    // Illegal code 0xA
    clear_stats();
    cmd_code_i = 4'hA; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin tick(); sample(c); end
    chk("ill_ce", ce_cnt, 0);
    chk("ill_acks", acks, 0);
    chk("ill_err", err_cnt, 1);
    chk("ill_done", done_cnt, 0);
    chk("ill_busy", busy_o, 1);
    start = 1'b0;
    tick();
    chk("ill_idle", busy_o, 0);

    // Reset asserted during the PROGRAM write strobe
    cmd_code_i = 4'd3; block_addr_i = 7'h00; other_addr_i = 16'h0001; tx_data_i = 16'h5A5A;
    start = 1'b1;
    for (int c = 1; c <= 10 && flash_we_n; c++) tick();
    chk("mid_we_seen", flash_we_n, 0);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_we_n", flash_we_n, 1);
    chk("mid_ce_n", flash_ce_n, 1);
    chk("mid_dq_oe", flash_dq_oe, 0);
    start = 1'b0;
    #2 rst_i = 1'b1;
    tick();
    chk("mid_idle_busy", busy_o, 0);
    chk("mid_idle_ce", flash_ce_n, 1);

    // Sequencer accepts a new command after the aborted one
    clear_stats();
    cmd_code_i = 4'd6; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin tick(); sample(c); end
    chk("post_acks", acks, 1);
    chk("post_dat", wr_dat[0], 16'h00B0);
    start = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
